// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART transmitter.
//   - state_t and its state constants (IDLE .. STOP2), kept as plain
//     3-bit localparams so the encoding matches the legacy transmitter
//   - parity selection constants PAR_EVEN / PAR_ODD
//   - MAX_FRAME_BITS: longest possible frame in serial bits
package uart_pkg;

    typedef logic [2:0] state_t;

    localparam state_t IDLE   = 3'd0;
    localparam state_t START  = 3'd1;
    localparam state_t DATA   = 3'd2;
    localparam state_t PARITY = 3'd3;
    localparam state_t STOP1  = 3'd4;
    localparam state_t STOP2  = 3'd5;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam int MAX_DATA_W     = 9;
    // start + data + parity + two stop bits
    localparam int MAX_FRAME_BITS = 1 + MAX_DATA_W + 1 + 2;

endpackage

// File: rtl/uart_baud_gen.sv
// Baud-rate bit timer.
//   clk, rst      : clock, synchronous active-high reset
//   restart       : hold the counter at 0 (asserted while the parent is idle)
//   div           : clocks per serial bit; 0 behaves as 1
//   bit_end       : high on the last clock of every serial bit
//   bit_end_next  : value bit_end will take after the next edge, so the
//                   parent can register outputs that must line up with it
module uart_baud_gen #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             restart,
    input  logic [DIV_W-1:0] div,
    output logic             bit_end,
    output logic             bit_end_next
);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] cnt_next;
    logic [DIV_W-1:0] last;

    always_comb begin
        last = (div == '0) ? '0 : div - DIV_W'(1);
        // Wrapping at the end of every bit restarts the count for the next
        // bit or state without the parent having to request it.
        if (restart || cnt >= last) begin
            cnt_next = '0;
        end else begin
            cnt_next = cnt + DIV_W'(1);
        end
        bit_end_next = (cnt_next == last);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            bit_end <= 1'b0;
        end else begin
            cnt     <= cnt_next;
            bit_end <= bit_end_next;
        end
    end

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter (5..9 data bits, runtime baud divisor,
// optional parity, 1 or 2 stop bits) with a valid/ready input handshake.
//   clk, rst    : clock, synchronous active-high reset
//   baud_div    : clocks per serial bit (0 treated as 1)
//   par_en      : insert a parity bit after the data bits
//   par_odd     : 0 = even parity, 1 = odd parity
//   stop2       : 1 = two stop bits
//   in_data     : word to transmit, taken when in_valid && in_ready
//   in_valid    : source has a word
//   in_ready    : transmitter is idle and can accept a word
//   tx_out      : serial line, idle high (registered)
//   busy        : frame in progress (registered)
//   frame_done  : one-cycle pulse on the last clock of the frame (registered)
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int DATA_W = 8,   // legal range 5..9
    parameter int DIV_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DIV_W-1:0]  baud_div,
    input  logic              par_en,
    input  logic              par_odd,
    input  logic              stop2,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              tx_out,
    output logic              busy,
    output logic              frame_done
);

    localparam int               IDX_W    = $clog2(DATA_W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

    state_t            state;
    state_t            state_nxt;
    logic [DATA_W-1:0] shift_reg;
    logic [DATA_W-1:0] shift_nxt;
    logic [IDX_W-1:0]  bit_idx;
    logic [IDX_W-1:0]  idx_nxt;
    logic [DIV_W-1:0]  div_q;
    logic [DIV_W-1:0]  div_sel;
    logic              par_en_q;
    logic              stop2_q;
    logic              par_bit_q;
    logic              accept;
    logic              bit_end;
    logic              bit_end_next;
    logic              tx_nxt;
    logic              done_nxt;

    assign in_ready = (state == IDLE);
    assign accept   = in_valid && in_ready;

    // While idle the timer sees the live divisor, so the first bit after an
    // accept is timed with the same value that is being latched.
    assign div_sel = in_ready ? baud_div : div_q;

    uart_baud_gen #(
        .DIV_W(DIV_W)
    ) u_baud_gen (
        .clk          (clk),
        .rst          (rst),
        .restart      (in_ready),
        .div          (div_sel),
        .bit_end      (bit_end),
        .bit_end_next (bit_end_next)
    );

    // Next-state, shift register and bit index.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_nxt = state;
        shift_nxt = shift_reg;
        idx_nxt   = bit_idx;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_nxt = START;
                    shift_nxt = in_data;
                    idx_nxt   = '0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_nxt = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_nxt = shift_reg >> 1;
                    if (bit_idx == LAST_IDX) begin
                        idx_nxt   = '0;
                        state_nxt = par_en_q ? PARITY : STOP1;
                    end else begin
                        idx_nxt = bit_idx + IDX_W'(1);
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_nxt = STOP1;
                end
            end
            STOP1: begin
                if (bit_end) begin
                    state_nxt = stop2_q ? STOP2 : IDLE;
                end
            end
            STOP2: begin
                if (bit_end) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state and registered, so they change
    // on the same edge as the state itself and carry no input-to-output path.
    always_comb begin
        case (state_nxt)
            START:   tx_nxt = 1'b0;
            DATA:    tx_nxt = shift_nxt[0];
            PARITY:  tx_nxt = par_bit_q;
            default: tx_nxt = 1'b1;
        endcase
        done_nxt = bit_end_next &&
                   ((state_nxt == STOP2) || (state_nxt == STOP1 && !stop2_q));
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (rst) begin
            state      <= IDLE;
            shift_reg  <= '0;
            bit_idx    <= '0;
            div_q      <= '0;
            par_en_q   <= 1'b0;
            stop2_q    <= 1'b0;
            par_bit_q  <= 1'b0;
            tx_out     <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            shift_reg  <= shift_nxt;
            bit_idx    <= idx_nxt;
            tx_out     <= tx_nxt;
            busy       <= (state_nxt != IDLE);
            frame_done <= done_nxt;
            if (accept) begin
                div_q     <= baud_div;
                par_en_q  <= par_en;
                stop2_q   <= stop2;
                // Parity is fixed at accept time because the shift register
                // is consumed while the data bits go out.
                par_bit_q <= (^in_data) ^ (par_odd == PAR_ODD);
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_cfg.sv
module tb_uart_tx_cfg;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] baud_div = 16'd1;
    logic        par_en = 1'b0;
    logic        par_odd = 1'b0;
    logic        stop2 = 1'b0;

    logic [7:0]  data_a = '0;
    logic        valid_a = 1'b0;
    logic        rdy_a, tx_a, busy_a, done_a;

    logic [4:0]  data_b = '0;
    logic        valid_b = 1'b0;
    logic        rdy_b, tx_b, busy_b, done_b;

    always #5 clk = ~clk;

    uart_tx_cfg #(.DATA_W(8), .DIV_W(16)) dut_a (
        .clk(clk), .rst(rst), .baud_div(baud_div), .par_en(par_en),
        .par_odd(par_odd), .stop2(stop2), .in_data(data_a), .in_valid(valid_a),
        .in_ready(rdy_a), .tx_out(tx_a), .busy(busy_a), .frame_done(done_a)
    );

    uart_tx_cfg #(.DATA_W(5), .DIV_W(16)) dut_b (
        .clk(clk), .rst(rst), .baud_div(baud_div), .par_en(par_en),
        .par_odd(par_odd), .stop2(stop2), .in_data(data_b), .in_valid(valid_b),
        .in_ready(rdy_b), .tx_out(tx_b), .busy(busy_b), .frame_done(done_b)
    );

    int total = 0;
    int bad   = 0;

    bit exp_q[$];
    bit cap_tx[$];
    bit cap_done[$];
    bit cap_rdy[$];

    typedef struct {
        int data;
        bit w5;
        int div;
        bit pe;
        bit po;
        bit s2;
        int exp_len;
        int exp_par;   // -1 when there is no parity bit
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Expected line, one entry per clock, built from the frame format:
    // start 0, data LSB first, optional parity, one or two stop 1s.
    function automatic void build_model(input int data, input int w, input int div,
                                        input bit pe, input bit po, input bit s2);
        int d;
        int ones;
        bit bits[$];
        d    = (div == 0) ? 1 : div;
        ones = 0;
        exp_q.delete();
        bits.push_back(1'b0);
        for (int i = 0; i < w; i++) begin
            bits.push_back(((data >> i) & 1) == 1);
            ones += (data >> i) & 1;
        end
        if (pe) bits.push_back(((ones % 2) == 1) ^ po);
        bits.push_back(1'b1);
        if (s2) bits.push_back(1'b1);
        foreach (bits[i]) begin
            for (int k = 0; k < d; k++) exp_q.push_back(bits[i]);
        end
    endfunction

    // Presents one word; returns at the negedge after the accept edge.
    task automatic start_frame(input bit w5, input int data, input int div,
                               input bit pe, input bit po, input bit s2, input bit hold);
        int n = 0;
        while (!(w5 ? rdy_b : rdy_a) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) check("ready_timeout", 0, 1);
        baud_div = div[15:0];
        par_en   = pe;
        par_odd  = po;
        stop2    = s2;
        if (w5) begin
            data_b  = data[4:0];
            valid_b = 1'b1;
        end else begin
            data_a  = data[7:0];
            valid_a = 1'b1;
        end
        @(negedge clk);
        if (!hold) begin
            valid_a = 1'b0;
            valid_b = 1'b0;
        end
    endtask

    // Records the line while busy; ends on the first idle negedge.
    task automatic capture(input bit w5);
        int n = 0;
        cap_tx.delete();
        cap_done.delete();
        cap_rdy.delete();
        while ((w5 ? busy_b : busy_a) && n < 2000) begin
            cap_tx.push_back(w5 ? tx_b : tx_a);
            cap_done.push_back(w5 ? done_b : done_a);
            cap_rdy.push_back(w5 ? rdy_b : rdy_a);
            @(negedge clk);
            n++;
        end
        if (n >= 2000) check("busy_timeout", 0, 1);
    endtask

    task automatic compare_frame(input string tag, input bit w5);
        int len;
        int n;
        len = cap_tx.size();
        n   = (len < exp_q.size()) ? len : exp_q.size();
        check({tag, " len"}, len, exp_q.size());
        for (int k = 0; k < n; k++) begin
            check($sformatf("%s tx[%0d]", tag, k), cap_tx[k], exp_q[k]);
            check($sformatf("%s done[%0d]", tag, k), cap_done[k], (k == exp_q.size() - 1) ? 1 : 0);
            check($sformatf("%s ready[%0d]", tag, k), cap_rdy[k], 0);
        end
        check({tag, " idle tx"}, w5 ? tx_b : tx_a, 1);
        check({tag, " idle ready"}, w5 ? rdy_b : rdy_a, 1);
        check({tag, " idle done"}, w5 ? done_b : done_a, 0);
    endtask

    task automatic frame(input string tag, input bit w5, input int data, input int div,
                         input bit pe, input bit po, input bit s2);
        start_frame(w5, data, div, pe, po, s2, 1'b0);
        build_model(data, w5 ? 5 : 8, div, pe, po, s2);
        capture(w5);
        compare_frame(tag, w5);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[6];
        int   d;
        int   idx;

        tbl[0] = '{data: 'hA5, w5: 0, div: 4, pe: 0, po: 0, s2: 0, exp_len: 40, exp_par: -1};
        tbl[1] = '{data: 'h07, w5: 0, div: 1, pe: 1, po: 0, s2: 0, exp_len: 11, exp_par: 1};
        tbl[2] = '{data: 'h07, w5: 0, div: 1, pe: 1, po: 1, s2: 0, exp_len: 11, exp_par: 0};
        tbl[3] = '{data: 'h07, w5: 0, div: 1, pe: 1, po: 0, s2: 1, exp_len: 12, exp_par: 1};
        tbl[4] = '{data: 'h1F, w5: 1, div: 0, pe: 0, po: 0, s2: 0, exp_len: 7,  exp_par: -1};
        tbl[5] = '{data: 'hC3, w5: 0, div: 3, pe: 1, po: 1, s2: 1, exp_len: 36, exp_par: 1};

        // Reset and idle line.
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check($sformatf("idle_a[%0d]", i), {tx_a, busy_a, rdy_a, done_a}, 4'b1010);
        end
        check("idle_b", {tx_b, busy_b, rdy_b, done_b}, 4'b1010);

        // Directed vectors.
        for (int i = 0; i < 6; i++) begin
            frame($sformatf("vec%0d", i), tbl[i].w5, tbl[i].data, tbl[i].div,
                  tbl[i].pe, tbl[i].po, tbl[i].s2);
            check($sformatf("vec%0d frame_len", i), cap_tx.size(), tbl[i].exp_len);
            if (tbl[i].exp_par >= 0) begin
                d   = (tbl[i].div == 0) ? 1 : tbl[i].div;
                idx = (1 + (tbl[i].w5 ? 5 : 8)) * d;
                check($sformatf("vec%0d parity", i),
                      (idx < cap_tx.size()) ? int'(cap_tx[idx]) : -1, tbl[i].exp_par);
            end
        end

        // Back-to-back with a divisor change during the first frame.
        start_frame(1'b0, 'h55, 2, 1'b0, 1'b0, 1'b0, 1'b1);
        baud_div = 16'd8;
        data_a   = 8'hFF;
        build_model('h55, 8, 2, 1'b0, 1'b0, 1'b0);
        capture(1'b0);
        compare_frame("b2b_first", 1'b0);
        @(negedge clk);
        valid_a = 1'b0;
        build_model('hFF, 8, 8, 1'b0, 1'b0, 1'b0);
        capture(1'b0);
        compare_frame("b2b_second", 1'b0);

        // Reset during data bit 3 (a 0 bit of 0x55), then a clean frame.
        start_frame(1'b0, 'h55, 2, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (8) @(negedge clk);
        check("pre_reset tx", tx_a, 0);
        check("pre_reset busy", busy_a, 1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_reset state", {tx_a, busy_a, rdy_a, done_a}, 4'b1010);
        rst = 1'b0;
        frame("post_reset", 1'b0, 'h3C, 2, 1'b0, 1'b0, 1'b0);

        // Randomized frames on both widths.
        for (int i = 0; i < 25; i++) begin
            frame($sformatf("rand%0d", i), 1'($urandom_range(0, 1)), int'($urandom_range(0, 511)),
                  int'($urandom_range(0, 5)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_cfg.md
Name: uart_tx_cfg

Overview:
- Parametrised UART transmitter, next generation of the team's fixed 8-bit transmitter.
- Adds:
  - configurable data width;
  - an internal baud-rate divider (bits no longer last one clk);
  - 1 or 2 stop bits;
  - a valid/ready input handshake;
  - a frame-done pulse.
- Sits between a byte source (FIFO or CPU register) and the serial pin.

Parameters:
- DATA_W, 8, data bits per frame; legal range 5..9.
- DIV_W, 16, width of runtime baud divisor.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- baud_div  in  DIV_W  clocks per serial bit; 0 is treated as 1.
- par_en  in  1  1 = insert parity bit after the data bits.
- par_odd  in  1  0 = even parity, 1 = odd parity.
- stop2  in  1  1 = two stop bits, 0 = one stop bit.
- in_data  in  DATA_W  word to transmit.
- in_valid  in  1  source has a word.
- in_ready  out  1  block can accept a word.
- tx_out  out  1  serial line, idle high.
- busy  out  1  frame in progress.
- frame_done  out  1  one-cycle pulse at end of frame.

Behaviour:
- Reset values: tx_out=1, busy=0, in_ready=1, frame_done=0, state IDLE, all counters 0.
- Reset is honoured in any state. A frame in progress is abandoned, and tx_out returns to 1 at the next edge.
- Handshake:
  - Accept occurs on a clk edge where in_valid && in_ready.
  - in_ready = 1 only in IDLE.
  - On accept, the block latches in_data, baud_div, par_en, par_odd and stop2. Config changes mid-frame have no effect until the next accept.
- Latency: at the accept edge the state becomes START. tx_out=0 and busy=1 from the following cycle.
- Bit timing: every serial bit lasts exactly D = max(baud_div,1) clk cycles, counted by the baud counter.
  - The counter restarts at 0 on each state entry.
  - A bit ends on the cycle the counter reaches D-1.
- States, with tx_out in each and where the state exits to:
  - IDLE: tx_out=1. Exits to START on accept.
  - START: tx_out=0. After one bit, goes to DATA.
  - DATA: tx_out=shift_reg[0], sent LSB first. A bit index runs 0..DATA_W-1 and the shift register shifts right at each bit end. After bit DATA_W-1, goes to PARITY if par_en, else to STOP1.
  - PARITY: tx_out = (^latched_data) ^ par_odd. After one bit, goes to STOP1.
  - STOP1: tx_out=1. After one bit, goes to STOP2 if stop2, else to IDLE.
  - STOP2: tx_out=1. After one bit, goes to IDLE.
- frame_done = 1 for the single cycle in which the final stop bit ends, i.e. the cycle before IDLE.
- busy = 1 in every state except IDLE.
- Frame length in clk cycles: D × (1 + DATA_W + par_en + 1 + stop2).
- Back-to-back:
  - With in_valid held high, the next accept happens on the first IDLE cycle.
  - Minimum gap between frames is 1 clk of idle-high line.
- Outputs tx_out, busy and frame_done are registered (no combinational path from inputs). in_ready is decoded from state.
- An illegal state encoding recovers to IDLE with tx_out=1.

Decomposition:
- Package uart_pkg holds:
  - state enum (IDLE, START, DATA, PARITY, STOP1, STOP2);
  - parity constants PAR_EVEN=0, PAR_ODD=1;
  - helper constant for maximum frame bits.
- Sub-module uart_baud_gen (DIV_W):
  - inputs clk, rst, restart, div;
  - output bit_end, a one-cycle pulse every max(div,1) cycles after restart.
- The FSM, shift register, bit index and parity stay in the top module.

Test Plan:
- Reset/idle: assert rst 3 cycles, then release with in_valid=0 -> tx_out=1, busy=0, in_ready=1 for 20 cycles.
- Basic frame: DATA_W=8, baud_div=4, no parity, 1 stop, send 0xA5.
  - Line sequence is 0,1,0,1,0,0,1,0,1,1, each level held 4 clks.
  - frame_done pulses at clk 40 after the start bit begins.
- Parity and 2 stops: baud_div=1, par_en=1.
  - 0x07 with even parity -> parity bit 1.
  - 0x07 with odd parity -> parity bit 0.
  - With stop2=1, the frame is 12 clks with two high stop bits.
- Back-to-back with config latching: in_valid held high for 0x55 then 0xFF, baud_div=2.
  - Change baud_div to 8 mid-frame -> first frame keeps 2-clk bits throughout.
  - Exactly one idle-high clk separates the frames.
  - Second frame uses 8-clk bits.
- Mid-frame reset: assert rst during bit 3 of DATA -> next cycle tx_out=1, busy=0, in_ready=1; a subsequent 0x3C frame is sent correctly.
- Width/divisor corners: DATA_W=5 with 0x1F, and baud_div=0.
  - 7-clk frame (bits of 1 clk each).
  - Line sequence 0,1,1,1,1,1,1.
